// File: rtl/msi001_spi_rx.sv
// Receive-side monitor for the MSi001 3-wire SPI write path: oversamples the bus,
// assembles MSB-first frames and keeps a 16-entry shadow copy of the tuner registers.
module msi001_spi_rx #(
    parameter int FRAME_BITS  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_msi001_data_in,
    input  logic        spi_msi001_clk_in,
    input  logic        spi_msi001_en_in,
    output logic [23:0] rx_word,
    output logic        rx_valid,
    output logic        rx_error,
    output logic [7:0]  err_count,
    input  logic [3:0]  rd_addr,
    output logic [19:0] rd_data
);

    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

    logic [SYNC_STAGES-1:0] r_data_sync;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_en_sync;
    logic                   r_clk_d;
    logic                   r_en_d;
    state_t                 r_state;
    logic [23:0]            r_shift;
    logic [4:0]             r_bit_cnt;
    logic [19:0]            r_regfile [16];

    logic w_data;
    logic w_clk_rise;
    logic w_en_rise;
    logic w_en_fall;

    // en synchronizer resets low so a frame already in progress at reset release
    // never produces a falling edge; only a fresh en assertion starts capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_sync <= '0;
            r_clk_sync  <= '0;
            r_en_sync   <= '0;
            r_clk_d     <= 1'b0;
            r_en_d      <= 1'b0;
        end else begin
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], spi_msi001_data_in};
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], spi_msi001_clk_in};
            r_en_sync   <= {r_en_sync[SYNC_STAGES-2:0], spi_msi001_en_in};
            r_clk_d     <= r_clk_sync[SYNC_STAGES-1];
            r_en_d      <= r_en_sync[SYNC_STAGES-1];
        end
    end

    assign w_data     = r_data_sync[SYNC_STAGES-1];
    assign w_clk_rise = r_clk_sync[SYNC_STAGES-1] & ~r_clk_d;
    assign w_en_rise  = r_en_sync[SYNC_STAGES-1] & ~r_en_d;
    assign w_en_fall  = ~r_en_sync[SYNC_STAGES-1] & r_en_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            rx_word   <= '0;
            rx_valid  <= 1'b0;
            rx_error  <= 1'b0;
            err_count <= '0;
            for (int i = 0; i < 16; i++) begin
                r_regfile[i] <= '0;
            end
        end else begin
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_en_fall) begin
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // A clock edge coinciding with the closing en edge still counts.
                    if (w_clk_rise) begin
                        r_shift <= {r_shift[22:0], w_data};
                        if (r_bit_cnt != 5'd31) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    if (w_en_rise) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_bit_cnt == FRAME_CNT) begin
                        rx_word                  <= r_shift;
                        r_regfile[r_shift[3:0]]  <= r_shift[23:4];
                        rx_valid                 <= 1'b1;
                    end else begin
                        rx_error <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_data = r_regfile[rd_addr];

endmodule

// File: tb/tb_msi001_spi_rx.sv
// Directed bench for msi001_spi_rx: drives SPI frames at clk/8 and checks the
// captured word, shadow registers, pulses and error counter against hand-computed values.
module tb_msi001_spi_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sdata = 1'b0;
    logic        sclk = 1'b0;
    logic        sen = 1'b1;
    logic [3:0]  rd_addr = 4'h0;
    logic [23:0] rx_word;
    logic        rx_valid;
    logic        rx_error;
    logic [7:0]  err_count;
    logic [19:0] rd_data;

    int n_cmp = 0;
    int n_bad = 0;
    int tot_valid = 0;
    int tot_error = 0;
    int viol = 0;
    logic prev_pulse = 1'b0;

    msi001_spi_rx #(.FRAME_BITS(24), .SYNC_STAGES(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .spi_msi001_data_in(sdata),
        .spi_msi001_clk_in (sclk),
        .spi_msi001_en_in  (sen),
        .rx_word           (rx_word),
        .rx_valid          (rx_valid),
        .rx_error          (rx_error),
        .err_count         (err_count),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) tot_valid++;
        if (rx_error) tot_error++;
        if ((rx_valid && rx_error) || ((rx_valid || rx_error) && prev_pulse)) viol++;
        prev_pulse = rx_valid | rx_error;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic en_low();
        @(negedge clk);
        sen = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdata = val[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic en_high(output int lat);
        repeat (2) @(negedge clk);
        sen = 1'b1;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (rx_valid || rx_error) break;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic frame(input logic [31:0] val, input int n, output int lat);
        en_low();
        shift_bits(val, n);
        en_high(lat);
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [19:0] d);
        @(negedge clk);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    initial begin
        int lat;
        int v0;
        int e0;
        logic [19:0] d;

        repeat (3) @(negedge clk);
        check("reset_rx_word", rx_word, 0);
        check("reset_err_count", err_count, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_error", rx_error, 0);
        for (int a = 0; a < 16; a++) begin
            read_reg(4'(a), d);
            check("reset_rd_data", d, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Valid frame at clk/8
        v0 = tot_valid; e0 = tot_error;
        frame(32'h00EBAEAB, 24, lat);
        check("t1_latency", lat, 4);
        check("t1_valid_cnt", tot_valid - v0, 1);
        check("t1_error_cnt", tot_error - e0, 0);
        check("t1_rx_word", rx_word, 24'hEBAEAB);
        read_reg(4'hB, d);
        check("t1_reg_b", d, 20'hEBAEA);

        // 23-bit frame is discarded
        v0 = tot_valid; e0 = tot_error;
        frame(32'h00123456, 23, lat);
        check("t2_latency", lat, 4);
        check("t2_valid_cnt", tot_valid - v0, 0);
        check("t2_error_cnt", tot_error - e0, 1);
        check("t2_err_count", err_count, 1);
        check("t2_rx_word", rx_word, 24'hEBAEAB);
        read_reg(4'hB, d);
        check("t2_reg_b", d, 20'hEBAEA);

        // 25-bit frame discarded, then a good frame to register 5
        v0 = tot_valid; e0 = tot_error;
        frame(32'h01ABCDEF, 25, lat);
        check("t3_error_cnt", tot_error - e0, 1);
        check("t3_valid_cnt", tot_valid - v0, 0);
        check("t3_err_count", err_count, 2);
        v0 = tot_valid; e0 = tot_error;
        frame(32'h00000015, 24, lat);
        check("t3b_valid_cnt", tot_valid - v0, 1);
        check("t3b_rx_word", rx_word, 24'h000015);
        read_reg(4'h5, d);
        check("t3b_reg_5", d, 20'h00001);

        // SPI clock and data activity with en high is ignored
        v0 = tot_valid; e0 = tot_error;
        for (int i = 0; i < 10; i++) begin
            sdata = ~sdata;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (6) @(negedge clk);
        check("t4_idle_pulses", (tot_valid - v0) + (tot_error - e0), 0);
        frame(32'h005A5A37, 24, lat);
        check("t4_valid_cnt", tot_valid - v0, 1);
        check("t4_error_cnt", tot_error - e0, 0);
        check("t4_rx_word", rx_word, 24'h5A5A37);
        read_reg(4'h7, d);
        check("t4_reg_7", d, 20'h5A5A3);
        read_reg(4'hB, d);
        check("t4_reg_b", d, 20'hEBAEA);

        // Reset in the middle of a frame
        v0 = tot_valid; e0 = tot_error;
        en_low();
        shift_bits(32'h00F0F0F0 >> 12, 12);
        rst = 1'b1;
        #1;
        check("t5_rst_rx_word", rx_word, 0);
        check("t5_rst_err_count", err_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        shift_bits(32'h000000F0, 12);
        en_high(lat);
        check("t5_valid_cnt", tot_valid - v0, 0);
        check("t5_error_cnt", tot_error - e0, 0);
        check("t5_rx_word", rx_word, 0);
        check("t5_err_count", err_count, 0);
        read_reg(4'hB, d);
        check("t5_reg_b", d, 0);
        read_reg(4'h7, d);
        check("t5_reg_7", d, 0);
        v0 = tot_valid;
        frame(32'h00C0FFEE, 24, lat);
        check("t5b_valid_cnt", tot_valid - v0, 1);
        check("t5b_rx_word", rx_word, 24'hC0FFEE);
        read_reg(4'hE, d);
        check("t5b_reg_e", d, 20'hC0FFE);

        // Error counter saturation
        e0 = tot_error;
        for (int i = 0; i < 260; i++) begin
            frame(32'h5, 4, lat);
        end
        check("t6_error_cnt", tot_error - e0, 260);
        check("t6_err_count", err_count, 255);
        v0 = tot_valid;
        frame(32'h00123452, 24, lat);
        check("t6_valid_cnt", tot_valid - v0, 1);
        check("t6_err_count_hold", err_count, 255);
        check("t6_rx_word", rx_word, 24'h123452);
        read_reg(4'h2, d);
        check("t6_reg_2", d, 20'h12345);

        check("pulse_exclusive", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/msi001_spi_rx.md
# msi001_spi_rx

Receive-side counterpart of the MSi001 3-wire SPI write path. Oversamples the data, SPI clock and active-low enable lines in the system clock domain and assembles MSB-first 24-bit frames. Each frame is split into a 4-bit register address (bits [3:0]) and 20-bit payload (bits [23:4]) and written into a 16-entry shadow register file. Used as a loopback monitor and tuner register model, so the team can read back what the tuner was programmed with.

## Interface
- FRAME_BITS, 24: bits per valid frame; the address/payload split assumes 24.
- SYNC_STAGES, 2: flip-flop stages on each input synchronizer, minimum 2.
- clk  in  1  system clock; must be at least 4x the SPI clock frequency.
- rst  in  1  asynchronous, active-high reset.
- spi_msi001_data_in  in  1  serial data, sampled on SPI clock rising edge.
- spi_msi001_clk_in  in  1  SPI clock, idle low.
- spi_msi001_en_in  in  1  frame enable, active low; a frame is bounded by its falling and rising edges.
- rx_word  out  24  last complete frame, held until the next valid frame.
- rx_valid  out  1  one-cycle pulse when rx_word and the register file update.
- rx_error  out  1  one-cycle pulse when a frame is discarded.
- err_count  out  8  saturating count of discarded frames.
- rd_addr  in  4  register file read address.
- rd_data  out  20  payload stored at rd_addr, combinational read.

## Operation
- Each input passes through a SYNC_STAGES synchronizer. Edges are detected by comparing the synchronized value with a one-cycle delayed copy.
- FSM states:
  - IDLE: wait for the synchronized en falling edge, then clear the shift register and 5-bit bit counter and go to SHIFT.
  - SHIFT: on each synchronized SPI clock rising edge, shift in data (shift_reg <= {shift_reg[22:0], data}) and increment the bit counter, saturating at 31. On the synchronized en rising edge, go to CHECK.
  - CHECK (one cycle):
    - If bit count == FRAME_BITS: rx_word <= shift_reg, regfile[shift_reg[3:0]] <= shift_reg[23:4], pulse rx_valid.
    - Otherwise: pulse rx_error, increment err_count (holds at 255), and leave rx_word and the register file unchanged.
    - Return to IDLE.
- SPI clock edges while en is high are ignored.
- Data changes without an SPI clock edge have no effect.
- If the SPI clock rising edge and the en rising edge are detected in the same cycle, take the clock edge first: shift the bit and count it, then go to CHECK.
- An en falling edge in CHECK is lost. Senders must keep en high for at least 2 clk cycles between frames.
- Reset, including mid-frame, sets the FSM to IDLE and clears the shift register, counter, rx_word, rx_valid, rx_error, err_count and all 16 register entries to 0.
- After reset deassert, a partial frame still in progress is ignored until the next en falling edge. This holds because the FSM waits for a falling edge, not a low level.

## Timing
- Reset values: rx_word 0, rx_valid 0, rx_error 0, err_count 0, rd_data 0 for every address.
- Latency: rx_valid or rx_error asserts SYNC_STAGES+2 clk edges after the first clk edge that samples en high. With the default, that is 4 edges.
- The register file write and the rx_word update become visible in the same cycle as the rx_valid pulse.
- rd_data follows rd_addr combinationally. A read of the address being written in the rx_valid cycle returns the new value.
- rx_valid and rx_error are mutually exclusive and are never asserted for 2 consecutive cycles.
- Minimum SPI clock high time and low time: 2 clk periods each.

## Test plan
- Send 24'hEBAEAB at SPI clock = clk/8 -> one rx_valid pulse, rx_word=24'hEBAEAB, rd_addr=4'hB gives rd_data=20'hEBAEA, rx_error stays 0.
- Send 23 bits, then deassert en -> one rx_error pulse, err_count=1, rx_word and register 0xB unchanged from the previous test.
- Send 25 bits -> rx_error pulse, err_count increments. Then send 24'h000015 -> rx_valid, register 5 = 20'h00001.
- Toggle the SPI clock 10 times with en high, then send one valid 24-bit frame -> only the frame is captured and the bit count is exactly 24.
- Assert rst after 12 bits of a frame, release it, finish the frame -> no rx_valid or rx_error pulse for that frame and all outputs stay 0. The next full frame is accepted.
- Send 260 short frames -> err_count saturates at 255. A following valid frame pulses rx_valid and leaves err_count at 255.
